mult_feeder: RTL
================

// Module: mult_feeder
// PURPOSE
// - Sequencer that drives the multiplier-switch array input interface (valid / data bus / stationary flag).
// - Pulls vectors from an upstream buffer over a valid/ready handshake.
// - Per job: issues one stationary-load vector, then streams N vectors with stationary low, then pulses done.
// - Sits between the distribution-network output buffer and the multiplier-switch array.
// PARAMETERS
// - IN_DATA_TYPE  32  bits per PE lane (32 fp32, 16 bf16, 8 int8)
// - NUM_PES       32  lanes on the data bus
// - LEN_W         16  width of the stream-length count
// PORTS
// - CLK           in   1                      clock, all logic on posedge
// - rst           in   1                      synchronous reset, active-low (0 = reset)
// - i_start       in   1                      job start; sampled only in IDLE
// - i_num_rows    in   LEN_W                  number of streaming vectors; latched on accepted i_start
// - i_src_valid   in   1                      upstream vector valid
// - i_src_data    in   NUM_PES*IN_DATA_TYPE   upstream vector
// - o_src_ready   out  1                      feeder accepts a vector this cycle
// - o_valid       out  1                      to array i_valid
// - o_data_bus    out  NUM_PES*IN_DATA_TYPE   to array i_data_bus
// - o_stationary  out  1                      to array i_stationary; 1 = load stationary operand
// - o_busy        out  1                      high from accepted start until done pulse (inclusive)
// - o_done        out  1                      one-cycle pulse at job end
// BEHAVIOUR
// - Reset (rst==0 at posedge): state IDLE; all outputs 0, including o_data_bus; row counter 0.
// - States: IDLE -> LOAD -> STREAM -> DONE -> IDLE.
// - IDLE:
//   - o_src_ready=0.
//   - On i_start=1: latch i_num_rows into rows_left, go to LOAD, assert o_busy next cycle.
// - LOAD:
//   - o_src_ready=1.
//   - On handshake (i_src_valid & o_src_ready): next cycle o_valid=1, o_stationary=1, o_data_bus=i_src_data.
//   - Then go to STREAM if rows_left!=0, else DONE.
// - STREAM:
//   - o_src_ready=1.
//   - Each handshake: next cycle o_valid=1, o_stationary=0, o_data_bus=i_src_data; rows_left decrements.
//   - Handshake with rows_left==1 moves to DONE.
// - DONE:
//   - o_src_ready=0; o_done=1 and o_busy=1 for exactly this cycle; next state IDLE.
//   - i_start in DONE is ignored; a new start takes effect from IDLE.
// - o_src_ready is a combinational function of state only; never depends on i_src_valid.
// - Outputs are registered: fixed 1-cycle latency from handshake to o_valid/o_data_bus/o_stationary.
// - Bubbles: cycle without handshake -> o_valid=0, o_stationary=0; o_data_bus holds last value (see macro).
// - o_stationary is never 1 while o_valid=0.
// - Exactly 1 + i_num_rows o_valid pulses per job; the last o_valid appears in the same cycle as o_done.
// - i_start while busy: ignored, no effect on count or state.
// - i_num_rows==0: job = single stationary vector, then DONE.
// - i_num_rows==2^LEN_W-1: counts fully with no wrap; rows_left never underflows.
// - i_src_valid while o_src_ready=0: no transfer, no output change.
// - Reset mid-job: abort immediately; IDLE; no done pulse; outputs 0 the cycle after reset.
// CONFIGURATION
// - FEEDER_ZERO_GATE_EN defined: o_data_bus is forced to 0 in every cycle where o_valid=0 (toggle suppression).
// - FEEDER_ZERO_GATE_EN undefined: o_data_bus holds its last driven value while o_valid=0.
// - o_valid, o_stationary and handshake timing are identical in both builds.
// TESTING
// - Reset: hold rst=0 for 3 cycles with random inputs -> all outputs 0, o_src_ready=0.
// - Basic job: start, num_rows=3, src_valid always 1, data 0xA,0xB,0xC,0xD per lane
//   -> o_valid 4 consecutive cycles, o_stationary only with 0xA, o_done in the 0xD cycle.
// - Bubbles: num_rows=2, src_valid pattern 1,0,0,1,1 -> o_valid 1,0,0,1,1 one cycle later.
//   - Macro on: data 0 in bubble cycles. Macro off: data holds.
// - Zero rows: num_rows=0 -> one o_valid with o_stationary=1, o_done same cycle, back to IDLE.
// - Start while busy: second i_start mid-STREAM with num_rows=7 -> ignored; original count completes.
// - Reset mid-job: rst=0 after 2 of 5 streamed rows -> no o_done; next job with num_rows=1 -> 2 o_valid pulses.

Source files
------------

// File: rtl/mult_feeder.sv
// Feeds the multiplier-switch array: one stationary-load vector, then N streamed vectors, then a done pulse.
// Optional FEEDER_ZERO_GATE_EN: zero the data bus on every cycle without a valid vector.
module mult_feeder #(
  parameter int IN_DATA_TYPE = 32,
  parameter int NUM_PES      = 32,
  parameter int LEN_W        = 16
) (
  input  logic                            CLK,
  input  logic                            rst,
  input  logic                            i_start,
  input  logic [LEN_W-1:0]                i_num_rows,
  input  logic                            i_src_valid,
  input  logic [NUM_PES*IN_DATA_TYPE-1:0] i_src_data,
  output logic                            o_src_ready,
  output logic                            o_valid,
  output logic [NUM_PES*IN_DATA_TYPE-1:0] o_data_bus,
  output logic                            o_stationary,
  output logic                            o_busy,
  output logic                            o_done
);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;

  state_t           state;
  logic [LEN_W-1:0] rows_left;
  logic             hs;

  // Handshake: a vector transfers on a cycle where i_src_valid and o_src_ready are both high.
  // o_src_ready depends on state only, so upstream may hold valid without combinational loops.
  assign o_src_ready = (state == LOAD) || (state == STREAM);
  assign hs          = i_src_valid && o_src_ready;

  always_ff @(posedge CLK) begin
    if (!rst) begin
      state        <= IDLE;
      rows_left    <= '0;
      o_valid      <= 1'b0;
      o_stationary <= 1'b0;
      o_data_bus   <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      o_valid      <= 1'b0;
      o_stationary <= 1'b0;
      o_done       <= 1'b0;
`ifdef FEEDER_ZERO_GATE_EN
      o_data_bus   <= '0;
`else
      o_data_bus   <= o_data_bus;
`endif
      case (state)
        IDLE: begin
          if (i_start) begin
            rows_left <= i_num_rows;
            o_busy    <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (hs) begin
            o_valid      <= 1'b1;
            o_stationary <= 1'b1;
            o_data_bus   <= i_src_data;
            // Done is registered alongside the last vector so both appear in the same cycle.
            if (rows_left == '0) begin
              o_done <= 1'b1;
              state  <= DONE;
            end else begin
              state  <= STREAM;
            end
          end
        end
        STREAM: begin
          if (hs) begin
            o_valid    <= 1'b1;
            o_data_bus <= i_src_data;
            rows_left  <= rows_left - 1'b1;
            if (rows_left == LEN_W'(1)) begin
              o_done <= 1'b1;
              state  <= DONE;
            end
          end
        end
        DONE: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
